// File: rtl/main_memory.sv
// rtl/main_memory.sv - byte-addressed big-endian main memory responder with 4-word burst
module main_memory #(
    parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
    parameter int unsigned DEPTH_BYTES = 1048576
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        enable_in,
    input  logic [31:0] addr_in,
    input  logic        rw_in,
    input  logic [1:0]  access_size_in,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        busy_out,
    output logic        error_out
);
    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_q, state_d;
    logic [1:0]    beat_q, beat_d;
    logic [AW-1:0] base_q, base_d;
    logic          burst_wr_q, burst_wr_d;
    logic [31:0]   data_out_q, data_out_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;

    logic [7:0]    mem [DEPTH_BYTES];

    logic [32:0]   req_off;
    logic [32:0]   req_bytes;
    logic          req_ok;
    logic [AW-1:0] acc_idx;
    logic [31:0]   rd_word;
    logic          wr_en;
    logic [1:0]    wr_size;

    assign req_off = {1'b0, addr_in} - {1'b0, BASE_ADDR};

    // Unknown sizes fall to default and are rejected like misaligned requests.
    always_comb begin
        req_ok    = 1'b0;
        req_bytes = 33'd1;
        case (access_size_in)
            2'b00: begin req_ok = 1'b1;                 req_bytes = 33'd1;  end
            2'b01: begin req_ok = ~addr_in[0];          req_bytes = 33'd2;  end
            2'b10: begin req_ok = (addr_in[1:0] == 2'b00); req_bytes = 33'd4;  end
            2'b11: begin req_ok = (addr_in[1:0] == 2'b00); req_bytes = 33'd16; end
            default: begin req_ok = 1'b0; req_bytes = 33'd1; end
        endcase
        if ((addr_in < BASE_ADDR) || ((req_off + req_bytes) > 33'(DEPTH_BYTES))) begin
            req_ok = 1'b0;
        end
    end

    assign acc_idx = (state_q == BURST) ? (base_q + AW'({beat_q, 2'b00})) : req_off[AW-1:0];
    assign rd_word = {mem[acc_idx], mem[acc_idx + AW'(1)], mem[acc_idx + AW'(2)], mem[acc_idx + AW'(3)]};

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        base_d     = base_q;
        burst_wr_d = burst_wr_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        wr_en      = 1'b0;
        wr_size    = 2'b10;
        case (state_q)
            IDLE: begin
                if (enable_in) begin
                    if (!req_ok) begin
                        error_d = 1'b1;
                    end else if (access_size_in == 2'b11) begin
                        state_d    = BURST;
                        beat_d     = 2'd1;
                        base_d     = req_off[AW-1:0];
                        burst_wr_d = rw_in;
                        if (rw_in) begin
                            wr_en = 1'b1;
                        end else begin
                            data_out_d = rd_word;
                            valid_d    = 1'b1;
                        end
                    end else if (rw_in) begin
                        wr_en   = 1'b1;
                        wr_size = access_size_in;
                    end else begin
                        valid_d = 1'b1;
                        case (access_size_in)
                            2'b00:   data_out_d = {24'h0, rd_word[31:24]};
                            2'b01:   data_out_d = {16'h0, rd_word[31:16]};
                            default: data_out_d = rd_word;
                        endcase
                    end
                end
            end
            BURST: begin
                if (burst_wr_q) begin
                    wr_en = 1'b1;
                end else begin
                    data_out_d = rd_word;
                    valid_d    = 1'b1;
                end
                if (beat_q == 2'd3) begin
                    state_d = IDLE;
                    beat_d  = 2'd0;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            case (wr_size)
                2'b00: mem[acc_idx] <= data_in[7:0];
                2'b01: begin
                    mem[acc_idx]          <= data_in[15:8];
                    mem[acc_idx + AW'(1)] <= data_in[7:0];
                end
                default: begin
                    mem[acc_idx]          <= data_in[31:24];
                    mem[acc_idx + AW'(1)] <= data_in[23:16];
                    mem[acc_idx + AW'(2)] <= data_in[15:8];
                    mem[acc_idx + AW'(3)] <= data_in[7:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            beat_q     <= 2'd0;
            base_q     <= '0;
            burst_wr_q <= 1'b0;
            data_out_q <= 32'h0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            base_q     <= base_d;
            burst_wr_q <= burst_wr_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_q;
    assign error_out = error_q;
    assign busy_out  = (state_q == BURST);
endmodule

// File: tb/tb_main_memory.sv
// tb/tb_main_memory.sv - directed self-checking bench for main_memory
module tb_main_memory;
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_BUR = 2'b11;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        enable_in = 1'b0;
    logic [31:0] addr_in = 32'h0;
    logic        rw_in = 1'b0;
    logic [1:0]  access_size_in = 2'b00;
    logic [31:0] data_in = 32'h0;
    logic [31:0] data_out;
    logic        valid_out;
    logic        busy_out;
    logic        error_out;

    int passed = 0;
    int total  = 0;

    main_memory dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .enable_in      (enable_in),
        .addr_in        (addr_in),
        .rw_in          (rw_in),
        .access_size_in (access_size_in),
        .data_in        (data_in),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .busy_out       (busy_out),
        .error_out      (error_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic rw, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        enable_in      = en;
        rw_in          = rw;
        access_size_in = sz;
        addr_in        = a;
        data_in        = d;
    endtask

    task automatic cyc(input logic en, input logic rw, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
        drive(en, rw, sz, a, d);
        @(posedge clk_in);
        #1;
    endtask

    task automatic flags(input string tag, input logic v, input logic b, input logic e);
        chk({tag, ".valid"}, 32'(valid_out), 32'(v));
        chk({tag, ".busy"},  32'(busy_out),  32'(b));
        chk({tag, ".error"}, 32'(error_out), 32'(e));
    endtask

    task automatic rd(input string tag, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] exp);
        cyc(1'b1, 1'b0, sz, a, 32'h0);
        chk({tag, ".data"}, data_out, exp);
        chk({tag, ".valid"}, 32'(valid_out), 32'd1);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst.data", data_out, 32'h0);
        flags("rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // word round-trip
        cyc(1'b1, 1'b1, SZ_W, 32'h8002_0000, 32'hDEAD_BEEF);
        flags("wr_word", 1'b0, 1'b0, 1'b0);
        rd("rd_word", SZ_W, 32'h8002_0000, 32'hDEAD_BEEF);

        // sub-word accesses
        rd("rd_byte", SZ_B, 32'h8002_0001, 32'h0000_00AD);
        rd("rd_half", SZ_H, 32'h8002_0002, 32'h0000_BEEF);
        cyc(1'b1, 1'b1, SZ_B, 32'h8002_0003, 32'h0000_0011);
        chk("wr_byte.valid", 32'(valid_out), 32'd0);
        rd("rd_after_byte", SZ_W, 32'h8002_0000, 32'hDEAD_BE11);

        // burst read, with an ignored write during the burst
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b1, SZ_W, 32'h8002_0010 + 32'(4 * k), 32'(k + 1));
        end
        cyc(1'b1, 1'b0, SZ_BUR, 32'h8002_0010, 32'h0);
        chk("burst.b0", data_out, 32'd1);
        flags("burst.b0", 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, SZ_W, 32'h8002_0000, 32'h0000_0BAD);
        chk("burst.b1", data_out, 32'd2);
        flags("burst.b1", 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
        chk("burst.b2", data_out, 32'd3);
        flags("burst.b2", 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
        chk("burst.b3", data_out, 32'd4);
        flags("burst.b3", 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
        chk("burst.hold", data_out, 32'd4);
        flags("burst.after", 1'b0, 1'b0, 1'b0);
        rd("burst.ignored_wr", SZ_W, 32'h8002_0000, 32'hDEAD_BE11);

        // burst write: data_in sampled on the accepting edge and the next three
        cyc(1'b1, 1'b1, SZ_BUR, 32'h8002_0020, 32'hA0A0_A0A0);
        flags("bwr.b0", 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, SZ_B, 32'h0, 32'hA1A1_A1A1);
        cyc(1'b0, 1'b0, SZ_B, 32'h0, 32'hA2A2_A2A2);
        chk("bwr.b2.busy", 32'(busy_out), 32'd1);
        cyc(1'b0, 1'b0, SZ_B, 32'h0, 32'hA3A3_A3A3);
        flags("bwr.b3", 1'b0, 1'b0, 1'b0);
        rd("bwr.rd0", SZ_W, 32'h8002_0020, 32'hA0A0_A0A0);
        rd("bwr.rd1", SZ_W, 32'h8002_0024, 32'hA1A1_A1A1);
        rd("bwr.rd2", SZ_W, 32'h8002_0028, 32'hA2A2_A2A2);
        rd("bwr.rd3", SZ_W, 32'h8002_002C, 32'hA3A3_A3A3);

        // rejected requests
        cyc(1'b1, 1'b1, SZ_W, 32'h8002_0002, 32'hFFFF_FFFF);
        flags("err.mis_word", 1'b0, 1'b0, 1'b1);
        rd("err.mis_word.rb", SZ_W, 32'h8002_0000, 32'hDEAD_BE11);
        chk("err.clear", 32'(error_out), 32'd0);
        cyc(1'b1, 1'b1, SZ_H, 32'h8002_0001, 32'h0000_FFFF);
        flags("err.mis_half", 1'b0, 1'b0, 1'b1);
        rd("err.mis_half.rb", SZ_W, 32'h8002_0000, 32'hDEAD_BE11);
        cyc(1'b1, 1'b0, SZ_W, 32'h7FFF_FFFC, 32'h0);
        flags("err.below", 1'b0, 1'b0, 1'b1);
        chk("err.below.hold", data_out, 32'hDEAD_BE11);
        cyc(1'b1, 1'b1, SZ_BUR, 32'h8011_FFF4, 32'h5555_5555);
        flags("err.burst_end", 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
        flags("err.burst_end.idle", 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, SZ_W, 32'h8011_FFFC, 32'h1234_5678);
        flags("top_word.wr", 1'b0, 1'b0, 1'b0);
        rd("top_word.rd", SZ_W, 32'h8011_FFFC, 32'h1234_5678);
        rd("top_byte.rd", SZ_B, 32'h8011_FFFF, 32'h0000_0078);

        // streaming word reads, enable held high
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b1, SZ_W, 32'h8002_0000 + 32'(4 * k), 32'h1000_0000 + 32'(k));
        end
        for (int k = 0; k < 8; k++) begin
            rd($sformatf("stream%0d", k), SZ_W, 32'h8002_0000 + 32'(4 * k), 32'h1000_0000 + 32'(k));
        end
        cyc(1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
        chk("stream.hold", data_out, 32'h1000_0007);
        chk("stream.idle.valid", 32'(valid_out), 32'd0);

        // reset mid-burst
        cyc(1'b1, 1'b0, SZ_BUR, 32'h8002_0000, 32'h0);
        chk("rstb.b0", data_out, 32'h1000_0000);
        chk("rstb.busy", 32'(busy_out), 32'd1);
        drive(1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
        #3;
        rst_n_in = 1'b0;
        #1;
        chk("rstb.data", data_out, 32'h0);
        flags("rstb", 1'b0, 1'b0, 1'b0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        cyc(1'b0, 1'b0, SZ_W, 32'h0, 32'h0);
        flags("rstb.after", 1'b0, 1'b0, 1'b0);
        rd("rstb.rd", SZ_W, 32'h8002_0004, 32'h1000_0001);
        chk("rstb.rd.busy", 32'(busy_out), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
